// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end with 2-entry prefetch FIFO and branch redirect
module ifetch_unit #(
  parameter int              PC_W     = 30,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_pc,
  input  logic            rom_ack,
  input  logic [15:0]     rom_instruction,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  output logic            dec_valid,
  output logic [15:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc,
  input  logic            dec_ready
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]      count_q, count_d;
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic [15:0]     instr_q [2];
  logic [PC_W-1:0] pc_q    [2];

  logic push, pop;
  logic unused_br_lsb;

  assign unused_br_lsb = br_target[0];

  assign rom_req   = (state_q == S_FETCH) && (count_q != 2'd2);
  assign rom_pc    = fetch_pc_q;
  assign dec_valid = (count_q != 2'd0);
  assign dec_instr = dec_valid ? instr_q[head_q] : 16'h0000;
  assign dec_pc    = dec_valid ? pc_q[head_q] : '0;

  // A redirect overrides any completion or pop in the same cycle.
  assign push = rom_req & rom_ack & ~br_valid;
  assign pop  = dec_valid & dec_ready & ~br_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (br_valid) begin
      state_d    = S_REDIR;
      fetch_pc_d = {br_target[PC_W-1:1], 1'b0};
      count_d    = 2'd0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
        S_REDIR: state_d = S_FETCH;
        S_FETCH: state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
      if (push) begin
        fetch_pc_d = fetch_pc_q + PC_W'(2);
        tail_d     = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q[0] <= 16'h0000;
      instr_q[1] <= 16'h0000;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else if (push) begin
      instr_q[tail_q] <= rom_instruction;
      pc_q[tail_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit: vector table, queue model, corner sequences
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req;
  logic [29:0] rom_pc;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_instruction;
  logic        br_valid = 1'b0;
  logic [29:0] br_target = '0;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [29:0] dec_pc;
  logic        dec_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  ifetch_unit #(.PC_W(30), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst(rst),
    .rom_req(rom_req), .rom_pc(rom_pc), .rom_ack(rom_ack), .rom_instruction(rom_instruction),
    .br_valid(br_valid), .br_target(br_target),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [29:0] pc);
    case (pc)
      30'h0:   return 16'h5CCD;
      30'h4:   return 16'h9200;
      30'h6:   return 16'h9A00;
      default: return pc[15:0] ^ 16'hA5A5;
    endcase
  endfunction

  always_comb rom_instruction = rom_word(rom_pc);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of {pc, word}, the next fetch address and a bubble flag.
  typedef struct { logic [29:0] pc; logic [15:0] in; } ent_t;
  ent_t        mq[$];
  logic [29:0] m_pc;
  logic        m_bubble;

  task automatic model_reset();
    mq.delete();
    m_pc     = 30'h0;
    m_bubble = 1'b1;
  endtask

  task automatic apply(input logic b, input logic [29:0] t, input logic a, input logic r);
    logic exp_req;
    br_valid = b; br_target = t; rom_ack = a; dec_ready = r;
    #1;
    exp_req = !m_bubble && (mq.size() < 2);
    chk("rom_req", {31'h0, rom_req}, {31'h0, exp_req});
    chk("rom_pc", {2'b0, rom_pc}, {2'b0, m_pc});
    chk("dec_valid", {31'h0, dec_valid}, {31'h0, mq.size() != 0});
    chk("dec_pc", {2'b0, dec_pc}, (mq.size() != 0) ? {2'b0, mq[0].pc} : 32'h0);
    chk("dec_instr", {16'h0, dec_instr}, (mq.size() != 0) ? {16'h0, mq[0].in} : 32'h0);
    if (b) begin
      mq.delete();
      m_pc     = {t[29:1], 1'b0};
      m_bubble = 1'b1;
    end else begin
      if (mq.size() != 0 && r) void'(mq.pop_front());
      if (exp_req && a) begin
        mq.push_back('{pc: m_pc, in: rom_word(m_pc)});
        m_pc = m_pc + 30'd2;
      end
      m_bubble = 1'b0;
    end
  endtask

  task automatic step(input logic b, input logic [29:0] t, input logic a, input logic r);
    @(negedge clk);
    apply(b, t, a, r);
  endtask

  task automatic reset_release(input logic a, input logic r);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    apply(1'b0, 30'h0, a, r);
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        req;
    logic [29:0] rpc;
    logic        vld;
    logic [29:0] dpc;
    logic [15:0] din;
  } vec_t;

  vec_t vt[18];
  logic [29:0] seen[$];

  initial begin
    vt[0]  = '{1, 1, 1, 0, 30'h0, 0, 30'h0, 16'h0000};
    vt[1]  = '{0, 1, 1, 0, 30'h0, 0, 30'h0, 16'h0000};
    vt[2]  = '{0, 1, 1, 1, 30'h0, 0, 30'h0, 16'h0000};
    vt[3]  = '{0, 1, 1, 1, 30'h2, 1, 30'h0, 16'h5CCD};
    vt[4]  = '{0, 1, 1, 1, 30'h4, 1, 30'h2, 16'hA5A7};
    vt[5]  = '{0, 1, 0, 1, 30'h6, 1, 30'h4, 16'h9200};
    vt[6]  = '{0, 1, 0, 0, 30'h8, 1, 30'h4, 16'h9200};
    vt[7]  = '{0, 1, 1, 0, 30'h8, 1, 30'h4, 16'h9200};
    vt[8]  = '{0, 1, 1, 1, 30'h8, 1, 30'h6, 16'h9A00};
    vt[9]  = '{0, 1, 1, 1, 30'hA, 1, 30'h8, 16'hA5AD};
    vt[10] = '{1, 1, 0, 0, 30'h0, 0, 30'h0, 16'h0000};
    vt[11] = '{0, 1, 0, 0, 30'h0, 0, 30'h0, 16'h0000};
    vt[12] = '{0, 1, 0, 1, 30'h0, 0, 30'h0, 16'h0000};
    vt[13] = '{0, 1, 0, 1, 30'h2, 1, 30'h0, 16'h5CCD};
    vt[14] = '{0, 1, 0, 0, 30'h4, 1, 30'h0, 16'h5CCD};
    vt[15] = '{0, 1, 1, 0, 30'h4, 1, 30'h0, 16'h5CCD};
    vt[16] = '{0, 1, 1, 1, 30'h4, 1, 30'h2, 16'hA5A7};
    vt[17] = '{0, 1, 1, 1, 30'h6, 1, 30'h4, 16'h9200};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = vt[i].rst; br_valid = 1'b0; br_target = '0;
      rom_ack = vt[i].ack; dec_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d.rom_req", i), {31'h0, rom_req}, {31'h0, vt[i].req});
      chk($sformatf("vec%0d.rom_pc", i), {2'b0, rom_pc}, {2'b0, vt[i].rpc});
      chk($sformatf("vec%0d.dec_valid", i), {31'h0, dec_valid}, {31'h0, vt[i].vld});
      chk($sformatf("vec%0d.dec_pc", i), {2'b0, dec_pc}, {2'b0, vt[i].dpc});
      chk($sformatf("vec%0d.dec_instr", i), {16'h0, dec_instr}, {16'h0, vt[i].din});
    end

    // Random ack/ready with no redirects, then with sporadic redirects.
    reset_release(1'b1, 1'b1);
    for (int i = 0; i < 400; i++)
      step(1'b0, 30'h0, 1'($urandom % 2), 1'($urandom % 2));
    for (int i = 0; i < 400; i++)
      step(1'($urandom % 12 == 0), 30'($urandom), 1'($urandom % 2), 1'($urandom % 2));

    // Redirect coinciding with an ack and a pop.
    reset_release(1'b1, 1'b0);
    step(1'b0, 30'h0, 1'b1, 1'b0);
    step(1'b1, 30'hD, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 30'h0, 1'b1, 1'b1);

    // PC wrap at the top of the address space.
    seen.delete();
    step(1'b1, 30'h3FFFFFFC, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 30'h0, 1'b1, 1'b1);
      if (dec_valid) seen.push_back(dec_pc);
    end
    chk("wrap.count", seen.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
    if (seen.size() >= 3) begin
      chk("wrap.pc0", {2'b0, seen[0]}, 32'h3FFFFFFC);
      chk("wrap.pc1", {2'b0, seen[1]}, 32'h3FFFFFFE);
      chk("wrap.pc2", {2'b0, seen[2]}, 32'h00000000);
    end

    // Asynchronous reset with a full FIFO.
    reset_release(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 30'h0, 1'b1, 1'b0);
    chk("full.dec_valid", {31'h0, dec_valid}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async.rom_req", {31'h0, rom_req}, 32'd0);
    chk("async.dec_valid", {31'h0, dec_valid}, 32'd0);
    chk("async.rom_pc", {2'b0, rom_pc}, 32'd0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    apply(1'b0, 30'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 30'h0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end: the initiator side of the instruction ROM interface.
- Drives a halfword program counter to the ROM and captures the returned 16-bit instructions, together with their PCs, into a 2-entry prefetch FIFO.
- Hands instructions to the decoder over a valid/ready handshake.
- Accepts branch redirects from execute. A redirect flushes the FIFO and restarts fetch at the target.

Parameters:
- PC_W, 30: program counter / ROM address width in bits.
- RESET_PC, 0: fetch address after reset. Must be even.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- rom_req  out  1  fetch request valid.
- rom_pc  out  PC_W  fetch address (byte address, bit 0 always 0).
- rom_ack  in  1  rom_instruction is valid for rom_pc in this cycle. May be tied high for a combinational ROM.
- rom_instruction  in  16  instruction word returned by the ROM.
- br_valid  in  1  redirect request, single-cycle pulse.
- br_target  in  PC_W  redirect address. Bit 0 is ignored and forced to 0.
- dec_valid  out  1  FIFO head is valid.
- dec_instr  out  16  instruction at FIFO head.
- dec_pc  out  PC_W  PC of the instruction at FIFO head.
- dec_ready  in  1  decoder consumes the head this cycle.

Behaviour:
- Reset (asynchronous, held while rst=1): state=S_BOOT, fetch_pc=RESET_PC, FIFO count=0, both entries cleared. Output values during reset:
  - rom_req=0, rom_pc=RESET_PC.
  - dec_valid=0, dec_instr=0, dec_pc=0.
- State machine, 3 states:
  - S_BOOT: rom_req=0. Moves unconditionally to S_FETCH on the first clock edge after rst deasserts.
  - S_FETCH: rom_req = (count < 2). rom_pc = fetch_pc.
  - S_REDIR: one-cycle bubble after a redirect. rom_req=0. Moves to S_FETCH next cycle.
  - br_valid=1 in any state except during reset moves to S_REDIR.
- ROM transfer:
  - A fetch completes only in a cycle with rom_req=1 and rom_ack=1.
  - On completion: {rom_instruction, fetch_pc} is pushed into the FIFO at the tail, and fetch_pc <= fetch_pc + 2.
  - No request state is kept across cycles. rom_pc may change while rom_req=1 and rom_ack=0, and the ROM must tolerate this.
  - Only one transfer per cycle.
- PC arithmetic: modulo 2^PC_W. 0x3FFFFFFE + 2 wraps to 0 with no flag. Bit 0 of fetch_pc is always 0.
- Decoder side:
  - dec_valid = (count != 0). dec_instr and dec_pc come straight from FIFO head registers (no combinational path from rom_*).
  - dec_instr and dec_pc read 0 when the FIFO is empty.
  - Pop when dec_valid & dec_ready.
- FIFO count rules (2 entries, circular, 1-bit pointers):
  - Push and pop in the same cycle: count unchanged.
  - Push is impossible when count=2, because rom_req=0 then.
  - Pop with count=0 is ignored.
- Latency:
  - An instruction acked in cycle N is visible on dec_* in cycle N+1.
  - With rom_ack tied high and dec_ready high, steady throughput is 1 instruction per cycle.
  - First rom_req goes high 1 cycle after reset release.
  - After a redirect in cycle N: rom_req=1 with rom_pc=target in cycle N+2, and dec_valid earliest in cycle N+3.
- Redirect priority (br_valid=1 in cycle N):
  - FIFO is flushed (count=0) and fetch_pc <= {br_target[PC_W-1:1],1'b0}.
  - Any ROM completion in cycle N is discarded: no push and no PC increment.
  - Any pop in cycle N is ignored for FIFO state. The decoder must itself discard the instruction presented in that cycle.
  - Redirect in S_BOOT: target replaces RESET_PC.
  - Back-to-back redirects: the last one wins.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight ROM cycle is abandoned.

Test Plan:
1. rom_ack tied high, ROM model returns 0x5CCD at 0, 0x9200 at 4, 0x9A00 at 6; dec_ready=1; release rst -> rom_req=1 one cycle later; dec_pc sequence 0,2,4,6,... on consecutive cycles; dec_instr at pc 0 = 0x5CCD.
2. dec_ready=0 -> exactly two pushes (pc 0, 2), then rom_req=0 and rom_pc holds at 4; raise dec_ready -> pops in order 0x5CCD then the pc-2 word, and fetch resumes at 4 with no gap or duplicate.
3. rom_ack random with 50% density, dec_ready random -> scoreboard sees every even PC in order, each instruction matches the ROM model, and there are no duplicates.
4. br_valid with br_target=0x0000000D in the same cycle as rom_ack=1 and a pop -> acked word dropped; FIFO empties next cycle; rom_pc=0x0C two cycles later; first dec_pc=0x0C.
5. fetch_pc preset through a redirect to 0x3FFFFFFC -> dec_pc sequence 0x3FFFFFFC, 0x3FFFFFFE, 0x00000000.
6. rst asserted asynchronously mid-stream while the FIFO is full -> rom_req=0 and dec_valid=0 before the next clock edge; after release, fetch restarts at RESET_PC=0.
